if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- IF-stage producer that feeds the IF/ID pipeline register: holds the PC, fetches from instruction memory over a req/ack handshake, and presents PC, PC+4 and Inst plus a write enable.
- Handles stall from the hazard unit and branch/jump redirect from ID.
- Uses a one-entry skid buffer so no fetched word is lost.
- All outputs are registered on the rising edge of Clk, so they are stable for the IF/ID falling-edge capture.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INST, 32'h0000_0000, bubble instruction (sll $0,$0,0)

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
Stall  in  1  hazard unit: IF/ID must hold; IF holds its current instruction
Redirect  in  1  ID: taken branch/jump; squash wrong-path fetch
Redirect_PC  in  32  redirect target; bits [1:0] forced to 0
IM_Req  out  1  instruction memory request
IM_Addr  out  32  request address, stable while IM_Req high
IM_Ack  in  1  one-cycle pulse, IM_Data valid; may arrive in the same cycle as IM_Req
IM_Data  in  32  fetched word
O_PC  out  32  PC of presented instruction
O_PC4  out  32  O_PC + 4
O_Inst  out  32  presented instruction, NOP_INST when invalid
O_Valid  out  1  presented instruction is real, not a bubble
O_EN  out  1  IF/ID write enable = ~Stall, combinational

Behaviour:
- Clock and reset: one clock, Clk; reset Rst_n is asynchronous, active-low.
- Reset values:
  - state = START; PC = RESET_PC; IM_Addr = RESET_PC; IM_Req = 0.
  - O_PC = 0, O_PC4 = 0, O_Inst = NOP_INST, O_Valid = 0; skid buffer empty.
- Registers: PC (next fetch address), IM_Addr (outstanding request address), O regs, skid regs.
- IM_Req = 1 in FETCH and KILL, else 0. IM_Addr changes only when no request is outstanding or on an Ack edge.
- Load condition for the O regs: load_ok = ~Stall | ~O_Valid. A bubble may be overwritten under stall.
- States:
  - START: next cycle go to FETCH, with IM_Addr = PC.
  - FETCH, Ack & Redirect: discard IM_Data; PC, IM_Addr <= Redirect_PC; O_Valid <= 0, O_Inst <= NOP_INST; stay in FETCH.
  - FETCH, ~Ack & Redirect: PC <= Redirect_PC; squash the O regs; go to KILL. IM_Addr is unchanged, so the request stays stable.
  - FETCH, Ack & load_ok: O_PC <= IM_Addr, O_PC4 <= IM_Addr+4, O_Inst <= IM_Data, O_Valid <= 1; PC, IM_Addr <= IM_Addr+4; stay in FETCH. Back-to-back fetch, 1 word/cycle with zero-wait memory.
  - FETCH, Ack & ~load_ok: word goes into the skid buffer with its PC; PC <= IM_Addr+4; go to HOLD.
  - FETCH, no Ack and no Redirect: hold everything.
  - KILL: wait for Ack; discard the data; IM_Addr <= PC; go to FETCH. A further Redirect in KILL updates PC only.
  - HOLD: IM_Req = 0.
    - Redirect: empty the skid; squash the O regs; PC, IM_Addr <= Redirect_PC; go to FETCH.
    - Else if ~Stall: skid → O regs with O_Valid = 1; IM_Addr <= PC; go to FETCH.
- Priority: Redirect > Stall > normal fetch. The squash happens even while Stall is high.
- When the O regs are not loaded and there is no squash: if ~Stall, the presented instruction was consumed, so O_Valid <= 0 and O_Inst <= NOP_INST. If Stall, hold.
- Arithmetic: PC+4 wraps modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
- Reset mid-request: returns to START immediately; the late Ack is ignored in START.
- Latency: an Ack at edge N puts the instruction on the O outputs after edge N, captured by IF/ID at the following falling edge.

Decomposition:
- Shared package if_pkg: state encoding (START, FETCH, KILL, HOLD), NOP_INST, RESET_PC default, instruction width constant 32.
- One sub-module: if_skid_buf, a one-entry PC+Inst holding register with load, drain and flush.

Test Plan:
- Zero-wait memory (Ack same cycle as Req), no stall → O_PC = 0, 4, 8, 12 on consecutive cycles, O_Valid = 1, O_EN = 1.
- 2-cycle wait memory → IM_Addr stable for 2 cycles per request; O_Valid = 0 with O_Inst = NOP_INST between words.
- Stall for 3 cycles while Ack arrives with O_Valid = 1 → word lands in skid, IM_Req = 0, O regs hold PC 4. After Stall drops, skid PC 8 is presented next, then fetch resumes at 12.
- Redirect to 32'h0000_0100 while a request to 8 is outstanding → KILL, the late word for 8 is discarded, next O_PC = 32'h100 with O_Valid = 1.
- Redirect and Stall asserted together → O_Valid = 0 and O_Inst = NOP_INST next cycle, PC = Redirect_PC.
- Rst_n pulsed low mid-wait, and PC at 32'hFFFF_FFFC → reset: all outputs return to reset values asynchronously. Wrap: next fetch address = 0.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the IF stage: fetch FSM state encoding, data width
// and default reset/bubble values.
package if_pkg;

  localparam int unsigned INST_W = 32;

  localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  // sll $0,$0,0
  localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_START,
    ST_FETCH,
    ST_KILL,
    ST_HOLD
  } fetch_state_e;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [INST_W-1:0] pc_plus4(input logic [INST_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding a fetched PC + instruction that arrived while
// the IF/ID register could not accept it.
//   clk, rst_n      : clock, async active-low reset
//   load            : capture in_pc / in_inst, mark valid
//   drain           : entry consumed, mark empty
//   flush           : discard entry (wins over load and drain)
//   pc, inst, valid : held entry
module if_skid_buf
  import if_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              drain,
  input  logic              flush,
  input  logic [INST_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic [INST_W-1:0] pc,
  output logic [INST_W-1:0] inst,
  output logic              valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      inst  <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      pc    <= in_pc;
      inst  <= in_inst;
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage producer for the IF/ID pipeline register. Owns the PC, fetches
// from instruction memory over a req/ack handshake, absorbs stalls with a
// one-entry skid buffer and squashes wrong-path fetches on redirect.
//   Clk, Rst_n         : clock (rising edge), async active-low reset
//   Stall              : IF/ID must hold its contents
//   Redirect,
//   Redirect_PC        : taken branch/jump target from ID (bits [1:0] ignored)
//   IM_Req, IM_Addr    : memory request; address stable while request is up
//   IM_Ack, IM_Data    : one-cycle response pulse with fetched word
//   O_PC, O_PC4,
//   O_Inst, O_Valid    : registered instruction presented to IF/ID
//   O_EN               : IF/ID write enable (~Stall)
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [INST_W-1:0] Redirect_PC,
  output logic              IM_Req,
  output logic [INST_W-1:0] IM_Addr,
  input  logic              IM_Ack,
  input  logic [INST_W-1:0] IM_Data,
  output logic [INST_W-1:0] O_PC,
  output logic [INST_W-1:0] O_PC4,
  output logic [INST_W-1:0] O_Inst,
  output logic              O_Valid,
  output logic              O_EN
);

  fetch_state_e      state_q;
  logic [INST_W-1:0] pc_q;
  logic [INST_W-1:0] im_addr_q;
  logic              im_req_q;
  logic [INST_W-1:0] o_pc_q;
  logic [INST_W-1:0] o_pc4_q;
  logic [INST_W-1:0] o_inst_q;
  logic              o_valid_q;

  logic [INST_W-1:0] redirect_tgt;
  logic              load_ok;
  logic              skid_load;
  logic              skid_drain;
  logic              skid_flush;
  logic [INST_W-1:0] skid_pc;
  logic [INST_W-1:0] skid_inst;
  logic              skid_valid;

  assign redirect_tgt = {Redirect_PC[INST_W-1:2], 2'b00};
  // A bubble in the O regs may be overwritten even while stalled.
  assign load_ok      = ~Stall | ~o_valid_q;

  assign skid_load  = (state_q == ST_FETCH) && IM_Ack && !Redirect && !load_ok;
  assign skid_drain = (state_q == ST_HOLD) && !Redirect && !Stall;
  assign skid_flush = (state_q == ST_HOLD) && Redirect;

  if_skid_buf u_skid (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .load    (skid_load),
    .drain   (skid_drain),
    .flush   (skid_flush),
    .in_pc   (im_addr_q),
    .in_inst (IM_Data),
    .pc      (skid_pc),
    .inst    (skid_inst),
    .valid   (skid_valid)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_START;
      pc_q      <= RESET_PC;
      im_addr_q <= RESET_PC;
      im_req_q  <= 1'b0;
      o_pc_q    <= '0;
      o_pc4_q   <= '0;
      o_inst_q  <= NOP_INST;
      o_valid_q <= 1'b0;
    end else begin
      // Default: an unstalled IF/ID consumed the presented word; later
      // assignments below override this for loads and squashes.
      if (!Stall) begin
        o_valid_q <= 1'b0;
        o_inst_q  <= NOP_INST;
      end

      case (state_q)
        ST_START: begin
          state_q   <= ST_FETCH;
          im_req_q  <= 1'b1;
          im_addr_q <= pc_q;
        end

        ST_FETCH: begin
          if (Redirect) begin
            pc_q      <= redirect_tgt;
            o_valid_q <= 1'b0;
            o_inst_q  <= NOP_INST;
            if (IM_Ack) begin
              im_addr_q <= redirect_tgt;
            end else begin
              // Request stays up on the old address until its Ack drains.
              state_q <= ST_KILL;
            end
          end else if (IM_Ack) begin
            if (load_ok) begin
              o_pc_q    <= im_addr_q;
              o_pc4_q   <= pc_plus4(im_addr_q);
              o_inst_q  <= IM_Data;
              o_valid_q <= 1'b1;
              pc_q      <= pc_plus4(im_addr_q);
              im_addr_q <= pc_plus4(im_addr_q);
            end else begin
              pc_q     <= pc_plus4(im_addr_q);
              state_q  <= ST_HOLD;
              im_req_q <= 1'b0;
            end
          end
        end

        ST_KILL: begin
          if (Redirect) begin
            pc_q <= redirect_tgt;
          end
          if (IM_Ack) begin
            // A redirect landing on the Ack cycle must not use the stale PC.
            im_addr_q <= Redirect ? redirect_tgt : pc_q;
            state_q   <= ST_FETCH;
          end
        end

        ST_HOLD: begin
          if (Redirect) begin
            o_valid_q <= 1'b0;
            o_inst_q  <= NOP_INST;
            pc_q      <= redirect_tgt;
            im_addr_q <= redirect_tgt;
            state_q   <= ST_FETCH;
            im_req_q  <= 1'b1;
          end else if (!Stall) begin
            o_pc_q    <= skid_pc;
            o_pc4_q   <= pc_plus4(skid_pc);
            o_inst_q  <= skid_inst;
            o_valid_q <= skid_valid;
            im_addr_q <= pc_q;
            state_q   <= ST_FETCH;
            im_req_q  <= 1'b1;
          end
        end

        default: begin
          state_q  <= ST_START;
          im_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign IM_Req  = im_req_q;
  assign IM_Addr = im_addr_q;
  assign O_PC    = o_pc_q;
  assign O_PC4   = o_pc4_q;
  assign O_Inst  = o_inst_q;
  assign O_Valid = o_valid_q;
  assign O_EN    = ~Stall;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Stall;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        IM_Req;
  logic [31:0] IM_Addr;
  logic        IM_Ack;
  logic [31:0] IM_Data;
  logic [31:0] O_PC;
  logic [31:0] O_PC4;
  logic [31:0] O_Inst;
  logic        O_Valid;
  logic        O_EN;

  localparam logic [31:0] NOP = 32'h0000_0000;

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (NOP)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Stall       (Stall),
    .Redirect    (Redirect),
    .Redirect_PC (Redirect_PC),
    .IM_Req      (IM_Req),
    .IM_Addr     (IM_Addr),
    .IM_Ack      (IM_Ack),
    .IM_Data     (IM_Data),
    .O_PC        (O_PC),
    .O_PC4       (O_PC4),
    .O_Inst      (O_Inst),
    .O_Valid     (O_Valid),
    .O_EN        (O_EN)
  );

  always #5 Clk = ~Clk;

  // Memory model: acks after wait_n full cycles of a held request (0 = same
  // cycle). Data is the bitwise inverse of the address.
  int unsigned wait_n;
  logic        force_ack;
  int unsigned mem_cnt;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                 mem_cnt <= 0;
    else if (!IM_Req || IM_Ack) mem_cnt <= 0;
    else                        mem_cnt <= mem_cnt + 1;
  end

  assign IM_Ack  = force_ack | (IM_Req && (mem_cnt == wait_n));
  assign IM_Data = ~IM_Addr;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic req, input logic [31:0] addr);
    chk({tag, ".valid"}, {31'b0, O_Valid}, {31'b0, v});
    chk({tag, ".inst"}, O_Inst, v ? ~pc : NOP);
    chk({tag, ".req"}, {31'b0, IM_Req}, {31'b0, req});
    chk({tag, ".addr"}, IM_Addr, addr);
    if (v) begin
      chk({tag, ".pc"}, O_PC, pc);
      chk({tag, ".pc4"}, O_PC4, pc + 32'd4);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".O_PC"}, O_PC, 32'h0);
    chk({tag, ".O_PC4"}, O_PC4, 32'h0);
    chk({tag, ".O_Inst"}, O_Inst, NOP);
    chk({tag, ".O_Valid"}, {31'b0, O_Valid}, 32'h0);
    chk({tag, ".IM_Req"}, {31'b0, IM_Req}, 32'h0);
    chk({tag, ".IM_Addr"}, IM_Addr, 32'h0);
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Zero-wait memory: streaming, stall into skid, redirects, stall+redirect.
    tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b1, 32'h4};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h8};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h8};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h8};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h8};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'hC};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h10};
    tbl[8]  = '{1'b0, 1'b1, 32'h103, 1'b0, 32'h0,   1'b1, 32'h100};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 32'h104};
    tbl[10] = '{1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   1'b1, 32'h200};
    tbl[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b1, 32'h204};
    tbl[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h204};
    tbl[13] = '{1'b1, 1'b1, 32'h300, 1'b0, 32'h0,   1'b1, 32'h300};
    tbl[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 1'b1, 32'h304};
    tbl[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h304, 1'b1, 32'h308};

    Rst_n       = 1'b0;
    Stall       = 1'b0;
    Redirect    = 1'b0;
    Redirect_PC = 32'h0;
    wait_n      = 0;
    force_ack   = 1'b0;
    #12;
    check_reset("reset");
    chk("reset.O_EN", {31'b0, O_EN}, 32'h1);
    @(negedge Clk);
    Rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      Stall       = tbl[i].stall;
      Redirect    = tbl[i].redir;
      Redirect_PC = tbl[i].rpc;
      #1;
      chk($sformatf("row%0d.O_EN", i), {31'b0, O_EN}, {31'b0, ~tbl[i].stall});
      step();
      check_out($sformatf("row%0d", i), tbl[i].exp_valid, tbl[i].exp_pc,
                tbl[i].exp_req, tbl[i].exp_addr);
    end
    Stall    = 1'b0;
    Redirect = 1'b0;

    // Asynchronous reset while streaming, then 1-cycle-wait memory.
    Rst_n = 1'b0;
    #1;
    check_reset("async_rst1");
    wait_n = 1;
    @(negedge Clk);
    Rst_n = 1'b1;
    step(); check_out("wait.e1", 1'b0, 32'h0, 1'b1, 32'h0);
    step(); check_out("wait.e2", 1'b0, 32'h0, 1'b1, 32'h0);
    step(); check_out("wait.e3", 1'b1, 32'h0, 1'b1, 32'h4);
    step(); check_out("wait.e4", 1'b0, 32'h0, 1'b1, 32'h4);
    step(); check_out("wait.e5", 1'b1, 32'h4, 1'b1, 32'h8);

    // Redirect while the request to 8 is still waiting: late word discarded.
    Redirect    = 1'b1;
    Redirect_PC = 32'h100;
    step(); check_out("kill.e6", 1'b0, 32'h0, 1'b1, 32'h8);
    Redirect = 1'b0;
    step(); check_out("kill.e7", 1'b0, 32'h0, 1'b1, 32'h100);
    step(); check_out("kill.e8", 1'b0, 32'h0, 1'b1, 32'h100);
    step(); check_out("kill.e9", 1'b1, 32'h100, 1'b1, 32'h104);

    // Reset mid-wait; a stray Ack in START is ignored; PC wrap at the top.
    Rst_n = 1'b0;
    #1;
    check_reset("async_rst2");
    wait_n    = 0;
    force_ack = 1'b1;
    @(negedge Clk);
    Rst_n = 1'b1;
    step(); check_out("start_ack", 1'b0, 32'h0, 1'b1, 32'h0);
    force_ack   = 1'b0;
    Redirect    = 1'b1;
    Redirect_PC = 32'hFFFF_FFFC;
    step(); check_out("wrap.redir", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    Redirect = 1'b0;
    step(); check_out("wrap.top", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);
    chk("wrap.pc4_zero", O_PC4, 32'h0);
    step(); check_out("wrap.zero", 1'b1, 32'h0, 1'b1, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
